// File: rtl/serial_nor16.sv
// serial_nor16: 16-bit serial frame receiver
// with parallel word and all-zeros (NOR) flag.
module serial_nor16 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        din_valid,
  input  logic        din,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] word,
  output logic        out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [15:0] sr, sr_n;
  logic [15:0] shifted;
  logic [15:0] word_n;
  logic        acc, acc_n;
  logic        out_n;
  logic        busy_n, done_n;

  // din enters at the far end so the first bit lands in the chosen slot
  assign shifted = LSB_FIRST ? {din, sr[15:1]}
                             : {sr[14:0], din};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    acc_n   = acc;
    word_n  = word;
    out_n   = out;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          cnt_n   = 5'd0;
          acc_n   = 1'b0;
        end
      end
      SHIFT: begin
        if (din_valid) begin
          sr_n  = shifted;
          acc_n = acc | din;
          cnt_n = cnt + 5'd1;
          if (cnt == 5'd15) begin
            word_n  = shifted;
            out_n   = ~(acc | din);
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (ack) begin
          if (start) begin
            state_n = SHIFT;
            cnt_n   = 5'd0;
            acc_n   = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SHIFT);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      sr    <= 16'h0000;
      acc   <= 1'b0;
      word  <= 16'h0000;
      out   <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sr    <= sr_n;
      acc   <= acc_n;
      word  <= word_n;
      out   <= out_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_nor16.sv
// tb_serial_nor16: directed vectors for serial_nor16,
// one LSB-first and one MSB-first instance on shared inputs.
module tb_serial_nor16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        din_valid;
  logic        din;
  logic        ack;
  logic        l_busy, l_done, l_out;
  logic [15:0] l_word;
  logic        m_busy, m_done, m_out;
  logic [15:0] m_word;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_nor16 #(.LSB_FIRST(1'b1)) u_lsb (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din_valid (din_valid),
    .din       (din),
    .ack       (ack),
    .busy      (l_busy),
    .done      (l_done),
    .word      (l_word),
    .out       (l_out)
  );

  serial_nor16 #(.LSB_FIRST(1'b0)) u_msb (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din_valid (din_valid),
    .din       (din),
    .ack       (ack),
    .busy      (m_busy),
    .done      (m_done),
    .word      (m_word),
    .out       (m_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // bits[i] is the i-th bit put on the wire
  task automatic run_frame(input  logic [15:0] bits,
                           input  int          stall_after,
                           input  int          stall_len,
                           input  bit          poke_start,
                           output int          busy_cyc,
                           output int          done_seen);
    busy_cyc  = 0;
    done_seen = 0;
    for (int i = 0; i < 16; i++) begin
      din       = bits[i];
      din_valid = 1'b1;
      start     = poke_start && (i == 5);
      if (l_busy) busy_cyc++;
      if (l_done) done_seen++;
      tick();
      start = 1'b0;
      if (i == stall_after) begin
        din_valid = 1'b0;
        din       = 1'b1;
        for (int s = 0; s < stall_len; s++) begin
          if (l_busy) busy_cyc++;
          if (l_done) done_seen++;
          tick();
        end
      end
    end
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  int bc, dn;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    ack       = 1'b0;
    #2;
    chk("rst_word", l_word, 16'h0000);
    chk("rst_out",  l_out,  1'b1);
    chk("rst_busy", l_busy, 1'b0);
    chk("rst_done", l_done, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 0xA5C3 LSB-first; MSB-first instance sees it bit-reversed
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(16'hA5C3, -1, 0, 1'b0, bc, dn);
    chk("a5_busycyc", bc, 16);
    chk("a5_early_done", dn, 0);
    chk("a5_done", l_done, 1'b1);
    chk("a5_busy", l_busy, 1'b0);
    chk("a5_word", l_word, 16'hA5C3);
    chk("a5_out",  l_out,  1'b0);
    chk("a5_mword", m_word, 16'hC3A5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("a5_idle_done", l_done, 1'b0);
    chk("a5_idle_busy", l_busy, 1'b0);
    chk("a5_hold_word", l_word, 16'hA5C3);

    // zeros with a 3-cycle stall after bit 7
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(16'h0000, 7, 3, 1'b0, bc, dn);
    chk("z_busycyc", bc, 19);
    chk("z_done", l_done, 1'b1);
    chk("z_word", l_word, 16'h0000);
    chk("z_out",  l_out,  1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // single one in the last position
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(16'h8000, -1, 0, 1'b0, bc, dn);
    chk("b15_word",  l_word, 16'h8000);
    chk("b15_out",   l_out,  1'b0);
    chk("b15_mword", m_word, 16'h0001);
    chk("b15_mout",  m_out,  1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // 0x8001 with start poked mid-frame
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(16'h8001, -1, 0, 1'b1, bc, dn);
    chk("m81_done", m_done, 1'b1);
    chk("m81_word", m_word, 16'h8001);
    chk("m81_out",  m_out,  1'b0);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      tick();
      chk("m81_hold_done", m_done, 1'b1);
      chk("m81_hold_word", m_word, 16'h8001);
    end
    start = 1'b0;

    // ack+start together: straight back into SHIFT
    ack   = 1'b1;
    start = 1'b1;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    chk("b2b_busy", m_busy, 1'b1);
    chk("b2b_done", m_done, 1'b0);
    run_frame(16'h0000, -1, 0, 1'b0, bc, dn);
    chk("b2b_busycyc", bc, 16);
    chk("b2b_done2", m_done, 1'b1);
    chk("b2b_word",  m_word, 16'h0000);
    chk("b2b_out",   m_out,  1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // reset mid-frame after 9 accepted bits
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      din       = 1'b1;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    din       = 1'b0;
    reset     = 1'b1;
    #2;
    chk("mr_busy", l_busy, 1'b0);
    chk("mr_word", l_word, 16'h0000);
    chk("mr_out",  l_out,  1'b1);
    tick();
    reset = 1'b0;
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (l_done) dn++;
      tick();
    end
    chk("mr_no_done", dn, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(16'h00FF, -1, 0, 1'b0, bc, dn);
    chk("ff_early_done", dn, 0);
    chk("ff_done", l_done, 1'b1);
    chk("ff_word", l_word, 16'h00FF);
    chk("ff_out",  l_out,  1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (l_done) dn++;
      tick();
    end
    chk("ff_one_done", dn, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_nor16.md
SERIAL_NOR16 -- requirements
Module: serial_nor16

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter LSB_FIRST, default 1, SHALL select bit order: 1 = first received bit lands in word[0]; 0 = first received bit lands in word[15].
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Port start  input  1  request to begin receiving a 16-bit frame.
REQ-006 Port din_valid  input  1  din carries a valid bit this cycle.
REQ-007 Port din  input  1  serial data bit.
REQ-008 Port ack  input  1  consumer acknowledges a completed frame.
REQ-009 Port busy  output  1  high while the frame is being received.
REQ-010 Port done  output  1  completed frame available on word and out.
REQ-011 Port word  output  16  last completed frame, parallel.
REQ-012 Port out  output  1  NOR of all 16 bits of the last completed frame (1 = frame was all zeros).

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT, DONE, all outputs registered.
REQ-014 IDLE: busy=0, done=0; start=1 at a clock edge SHALL enter SHIFT, clearing the bit counter (5-bit, 0..16) and the running-OR accumulator.
REQ-015 SHIFT: busy=1; each edge with din_valid=1 SHALL accept din into the shift register, OR it into the accumulator, and increment the counter.
REQ-016 SHIFT with din_valid=0 SHALL hold counter, shift register and accumulator unchanged (stall, no timeout).
REQ-017 The edge that accepts the 16th bit SHALL load word from the completed shift register, load out = NOT(accumulator OR din), and enter DONE; done is high in the following cycle (latency: 1 cycle after the 16th accepted bit).
REQ-018 With LSB_FIRST=1 the shift register SHALL shift right with din entering bit 15; with LSB_FIRST=0 it SHALL shift left with din entering bit 0.
REQ-019 DONE: done=1, busy=0; word and out SHALL stay stable until ack=1 is sampled.
REQ-020 DONE with ack=1 and start=0 SHALL return to IDLE; with ack=1 and start=1 SHALL enter SHIFT directly (back-to-back frames, counter and accumulator cleared).
REQ-021 start in SHIFT, start without ack in DONE, and din_valid in IDLE or DONE SHALL be ignored.
REQ-022 word and out SHALL change only at frame completion; they hold the previous frame's values through IDLE and SHIFT.
REQ-023 ack outside DONE SHALL have no effect.

Reset
REQ-024 reset=1 SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, word=16'h0000, out=1, counter=0, accumulator=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; no done pulse follows release.
REQ-026 After reset release, the first start SHALL be honoured at the first rising edge it is sampled.

Verification
REQ-027 Reset then idle -> word=0x0000, out=1, busy=0, done=0 before any clock edge.
REQ-028 LSB_FIRST=1, start, then 16 consecutive valid bits forming 0xA5C3 LSB-first -> done=1 one cycle after 16th bit, word=0xA5C3, out=0; busy high for exactly 16 cycles.
REQ-029 16 valid zero bits with din_valid dropped for 3 cycles after bit 7 -> done after 19 SHIFT cycles, word=0x0000, out=1; a single 1 bit at position 15 instead -> word=0x8000, out=0.
REQ-030 LSB_FIRST=0, stream 0x8001 MSB-first -> word=0x8001, out=0; done held 5 cycles without ack, word unchanged; start during SHIFT ignored.
REQ-031 In DONE assert ack and start together, then stream 0x0000 -> no IDLE cycle, busy=1 next cycle, second done with word=0x0000, out=1.
REQ-032 Assert reset after 9 accepted bits, release, start a new 16-bit frame 0x00FF -> only one done, word=0x00FF, out=0.
